// File: rtl/riscv_pkg.sv
// riscv_pkg: shared integer-datapath widths and types
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0] xword_t;
endpackage

// File: rtl/regfile_bank.sv
// regfile_bank: 31-entry integer register storage, one write port, three read ports
module regfile_bank
    import riscv_pkg::*;
(
    input  logic     clk_i,
    input  logic     reset_i,
    input  reg_idx_t wr_index,
    input  xword_t   wr_value,
    input  logic     wr_en,
    input  reg_idx_t rs1_index,
    input  reg_idx_t rs2_index,
    input  reg_idx_t dbg_index,
    output xword_t   rs1_value,
    output xword_t   rs2_value,
    output xword_t   dbg_value
);
    xword_t bank [1:31];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 1; i < 32; i++) bank[i] <= '0;
        end else if (wr_en && wr_index != REG_ZERO) begin
            bank[wr_index] <= wr_value;
        end
    end

    // x0 is not stored; the guard keeps the index inside the declared range
    always_comb begin
        rs1_value = (rs1_index == REG_ZERO) ? '0 : bank[rs1_index];
        rs2_value = (rs2_index == REG_ZERO) ? '0 : bank[rs2_index];
        dbg_value = (dbg_index == REG_ZERO) ? '0 : bank[dbg_index];
    end
endmodule

// File: rtl/id_operand_fetch.sv
// id_operand_fetch: register read with WB bypass into the ID/EX operand register
module id_operand_fetch
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter bit REFRESH_ON_STALL = 1'b1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [4:0]      rd_index_w,
    input  logic [XLEN-1:0] rd_value_reg,
    input  logic            rd_we_w,
    input  logic            id_valid_i,
    input  logic [4:0]      id_rs1_index_i,
    input  logic [4:0]      id_rs2_index_i,
    input  logic            id_stall_i,
    input  logic            id_flush_i,
    output logic            ex_valid_r,
    output logic [4:0]      ex_rs1_index_r,
    output logic [4:0]      ex_rs2_index_r,
    output logic [XLEN-1:0] ex_rs1_value_r,
    output logic [XLEN-1:0] ex_rs2_value_r,
    input  logic [4:0]      dbg_index_i,
    output logic [XLEN-1:0] dbg_value_o
);
    xword_t bank_rs1, bank_rs2, rs1_value, rs2_value;
    logic wb_live;

    regfile_bank u_bank (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_index  (rd_index_w),
        .wr_value  (rd_value_reg),
        .wr_en     (rd_we_w),
        .rs1_index (id_rs1_index_i),
        .rs2_index (id_rs2_index_i),
        .dbg_index (dbg_index_i),
        .rs1_value (bank_rs1),
        .rs2_value (bank_rs2),
        .dbg_value (dbg_value_o)
    );

    always_comb begin
        wb_live = rd_we_w && rd_index_w != REG_ZERO;
        rs1_value = (id_rs1_index_i == REG_ZERO) ? '0 :
                    (wb_live && rd_index_w == id_rs1_index_i) ? rd_value_reg : bank_rs1;
        rs2_value = (id_rs2_index_i == REG_ZERO) ? '0 :
                    (wb_live && rd_index_w == id_rs2_index_i) ? rd_value_reg : bank_rs2;
    end

    // reset and flush both produce an all-zero bubble
    always_ff @(posedge clk_i) begin
        if (reset_i || id_flush_i) begin
            ex_valid_r     <= 1'b0;
            ex_rs1_index_r <= '0;
            ex_rs2_index_r <= '0;
            ex_rs1_value_r <= '0;
            ex_rs2_value_r <= '0;
        end else if (id_stall_i) begin
            if (REFRESH_ON_STALL && wb_live && ex_rs1_index_r == rd_index_w) ex_rs1_value_r <= rd_value_reg;
            if (REFRESH_ON_STALL && wb_live && ex_rs2_index_r == rd_index_w) ex_rs2_value_r <= rd_value_reg;
        end else begin
            ex_valid_r     <= id_valid_i;
            ex_rs1_index_r <= id_rs1_index_i;
            ex_rs2_index_r <= id_rs2_index_i;
            ex_rs1_value_r <= rs1_value;
            ex_rs2_value_r <= rs2_value;
        end
    end
endmodule

// File: tb/tb_id_operand_fetch.sv
// tb_id_operand_fetch: scoreboard bench for the operand fetch stage and its register bank
module tb_id_operand_fetch;
    typedef struct packed {
        logic        v;
        logic [4:0]  i1;
        logic [4:0]  i2;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic clk_i = 1'b0, reset_i, rd_we_w, id_valid_i, id_stall_i, id_flush_i;
    logic [4:0] rd_index_w, id_rs1_index_i, id_rs2_index_i, dbg_index_i;
    logic [31:0] rd_value_reg, dbg_value_o;
    logic ex_valid_r;
    logic [4:0] ex_rs1_index_r, ex_rs2_index_r;
    logic [31:0] ex_rs1_value_r, ex_rs2_value_r;

    int checks = 0, failures = 0;
    exp_t sb [$];
    exp_t e, obs;
    logic [31:0] model [32];

    assign obs = {ex_valid_r, ex_rs1_index_r, ex_rs2_index_r, ex_rs1_value_r, ex_rs2_value_r};

    always #5 clk_i = ~clk_i;

    id_operand_fetch dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .rd_index_w(rd_index_w), .rd_value_reg(rd_value_reg), .rd_we_w(rd_we_w),
        .id_valid_i(id_valid_i), .id_rs1_index_i(id_rs1_index_i), .id_rs2_index_i(id_rs2_index_i),
        .id_stall_i(id_stall_i), .id_flush_i(id_flush_i),
        .ex_valid_r(ex_valid_r), .ex_rs1_index_r(ex_rs1_index_r), .ex_rs2_index_r(ex_rs2_index_r),
        .ex_rs1_value_r(ex_rs1_value_r), .ex_rs2_value_r(ex_rs2_value_r),
        .dbg_index_i(dbg_index_i), .dbg_value_o(dbg_value_o)
    );

    task automatic drive(input logic we, input logic [4:0] wi, input logic [31:0] wv,
                         input logic vl, input logic [4:0] r1, input logic [4:0] r2);
        rd_we_w = we; rd_index_w = wi; rd_value_reg = wv;
        id_valid_i = vl; id_rs1_index_i = r1; id_rs2_index_i = r2;
    endtask

    task automatic tick();
        if (rd_we_w && rd_index_w != 5'd0 && !reset_i) model[rd_index_w] = rd_value_reg;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) model[i] = '0;
        reset_i = 1'b1; id_stall_i = 1'b0; id_flush_i = 1'b0; dbg_index_i = 5'd5;
        drive(1'b1, 5'd5, 32'hAAAA_5555, 1'b1, 5'd5, 5'd5);
        tick();
        tick();
        reset_i = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        sb.push_back('0);
        e = sb.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL reset_ex got=%h exp=%h", obs, e); end
        #1; checks++;
        if (dbg_value_o !== 32'h0) begin failures++; $display("FAIL reset_dbg_x5 got=%h exp=0", dbg_value_o); end
    endtask

    task automatic test_write_read();
        drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
        sb.push_back({1'b1, 5'd3, 5'd0, 32'hDEAD_BEEF, 32'h0});
        tick();
        e = sb.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL write_read got=%h exp=%h", obs, e); end
        dbg_index_i = 5'd3; #1; checks++;
        if (dbg_value_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL dbg_x3 got=%h exp=deadbeef", dbg_value_o); end
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 5'd7);
        dbg_index_i = 5'd7; #1; checks++;
        if (dbg_value_o !== 32'h0) begin failures++; $display("FAIL dbg_prewrite got=%h exp=0", dbg_value_o); end
        sb.push_back({1'b1, 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678});
        tick();
        e = sb.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL bypass got=%h exp=%h", obs, e); end
        checks++;
        if (dbg_value_o !== 32'h1234_5678) begin failures++; $display("FAIL dbg_postwrite got=%h exp=12345678", dbg_value_o); end
    endtask

    task automatic test_x0();
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd3);
        sb.push_back({1'b1, 5'd0, 5'd3, 32'h0, 32'hDEAD_BEEF});
        tick();
        e = sb.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL x0_same_cycle got=%h exp=%h", obs, e); end
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
        sb.push_back({1'b1, 5'd0, 5'd0, 32'h0, 32'h0});
        tick();
        e = sb.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL x0_next_cycle got=%h exp=%h", obs, e); end
        dbg_index_i = 5'd0; #1; checks++;
        if (dbg_value_o !== 32'h0) begin failures++; $display("FAIL dbg_x0 got=%h exp=0", dbg_value_o); end
    endtask

    task automatic test_stall_refresh();
        drive(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd9);
        sb.push_back({1'b1, 5'd3, 5'd9, 32'hDEAD_BEEF, 32'h1});
        tick();
        e = sb.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL stall_setup got=%h exp=%h", obs, e); end
        id_stall_i = 1'b1;
        drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd0);
        sb.push_back({1'b1, 5'd3, 5'd9, 32'hDEAD_BEEF, 32'h55});
        tick();
        e = sb.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL stall_refresh got=%h exp=%h", obs, e); end
        drive(1'b1, 5'd4, 32'h77, 1'b0, 5'd4, 5'd4);
        sb.push_back({1'b1, 5'd3, 5'd9, 32'hDEAD_BEEF, 32'h55});
        tick();
        e = sb.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL stall_hold got=%h exp=%h", obs, e); end
    endtask

    task automatic test_flush();
        id_stall_i = 1'b1; id_flush_i = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd9);
        sb.push_back('0);
        tick();
        e = sb.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL flush_over_stall got=%h exp=%h", obs, e); end
        id_stall_i = 1'b0; id_flush_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic we, vl;
        logic [4:0] wi, r1, r2;
        logic [31:0] wv, a, b;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1)); wi = 5'($urandom_range(0, 7)); wv = $urandom;
            vl = 1'($urandom_range(0, 1)); r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
            a = (r1 == 5'd0) ? 32'h0 : (we && wi == r1) ? wv : model[r1];
            b = (r2 == 5'd0) ? 32'h0 : (we && wi == r2) ? wv : model[r2];
            drive(we, wi, wv, vl, r1, r2);
            sb.push_back({vl, r1, r2, a, b});
            tick();
            e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL back_to_back[%0d] got=%h exp=%h", n, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_x0();
        test_stall_refresh();
        test_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
